iomem_arbiter: RTL



---
 rtl/iomem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the iomem valid/ready bus between the CPU (m0) and graphics engine (m1).
// Optional stall watchdog is compiled in with `define IOMEM_ARB_WATCHDOG_EN.
module iomem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        timeout_err_clr
);

  // Handshake: a transaction completes in the cycle where valid and ready are both high;
  // requesters hold valid and payload stable until they see ready.

  // State encoding doubles as the one-hot grant, so grant is registered for free.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_M0 = 2'b01,
    BUSY_M1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;  // 0 = m0 served last, 1 = m1 served last
  logic   fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  assign grant = state;

`ifdef IOMEM_ARB_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic        sel_valid;

  assign sel_valid = (state == BUSY_M0) ? m0_valid :
                     (state == BUSY_M1) ? m1_valid : 1'b0;
  // Fires on the stall cycle that would bring the count up to TIMEOUT_CYCLES.
  assign fire = sel_valid & !s_ready & (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= 16'd0;
    end else if (state == IDLE) begin
      wd_cnt <= 16'd0;
    end else if (s_valid && !s_ready) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else if (fire) begin
      timeout_err <= 1'b1;
    end else if (timeout_err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign fire        = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{timeout_err_clr, 16'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    s_valid   = 1'b0;
    s_wstrb   = 4'd0;
    s_addr    = 32'd0;
    s_wdata   = 32'd0;
    m0_ready  = 1'b0;
    m0_rdata  = 32'd0;
    m1_ready  = 1'b0;
    m1_rdata  = 32'd0;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = last ? BUSY_M0 : BUSY_M1;
        end else if (m0_valid) begin
          state_nxt = BUSY_M0;
        end else if (m1_valid) begin
          state_nxt = BUSY_M1;
        end
      end
      BUSY_M0: begin
        s_wstrb = m0_wstrb;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        if (fire) begin
          m0_ready  = 1'b1;
          m0_rdata  = 32'hFFFF_FFFF;
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end else begin
          s_valid  = m0_valid;
          m0_ready = s_ready & m0_valid;
          m0_rdata = s_rdata;
          if (m0_valid && s_ready) begin
            state_nxt = IDLE;
            last_nxt  = 1'b0;
          end else if (!m0_valid) begin
            state_nxt = IDLE;  // abandoned request: fairness history untouched
          end
        end
      end
      BUSY_M1: begin
        s_wstrb = m1_wstrb;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        if (fire) begin
          m1_ready  = 1'b1;
          m1_rdata  = 32'hFFFF_FFFF;
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end else begin
          s_valid  = m1_valid;
          m1_ready = s_ready & m1_valid;
          m1_rdata = s_rdata;
          if (m1_valid && s_ready) begin
            state_nxt = IDLE;
            last_nxt  = 1'b1;
          end else if (!m1_valid) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
